// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, IR field
// constants, ALU operation codes and the datapath control bundle.
package mips_pkg;

  localparam int unsigned OP_W  = 6;
  localparam int unsigned ALU_W = 3;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXR, S_WBR, S_EXI, S_WBI, S_ADDR, S_MRD,
    S_WBL, S_MWR, S_BR, S_JMP, S_JAL, S_JR, S_ERR
  } state_t;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;

  localparam logic [OP_W-1:0] FN_JR  = 6'b001000;
  localparam logic [OP_W-1:0] FN_ADD = 6'b100000;
  localparam logic [OP_W-1:0] FN_SUB = 6'b100010;
  localparam logic [OP_W-1:0] FN_AND = 6'b100100;
  localparam logic [OP_W-1:0] FN_OR  = 6'b100101;
  localparam logic [OP_W-1:0] FN_SLT = 6'b101010;

  localparam logic [ALU_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALU_W-1:0] ALU_SUB = 3'b110;
  localparam logic [ALU_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALU_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALU_W-1:0] ALU_SLT = 3'b111;

  typedef struct packed {
    logic             iord;
    logic             ir_write;
    logic             pc_write;
    logic             pc_write_cond;
    logic             br_flag;
    logic             reg_dst;
    logic             wr_sel;
    logic             wd_sel;
    logic             reg_write;
    logic             alu_src_a;
    logic             mem_to_reg;
    logic             mem_read;
    logic             mem_write;
    logic [1:0]       alu_src_b;
    logic [1:0]       pc_src;
    logic [ALU_W-1:0] alu_op;
  } ctrl_t;

  // R-type func decode: {valid, alu_op}
  function automatic logic [ALU_W:0] func_decode(input logic [OP_W-1:0] fn);
    case (fn)
      FN_ADD:  func_decode = {1'b1, ALU_ADD};
      FN_SUB:  func_decode = {1'b1, ALU_SUB};
      FN_AND:  func_decode = {1'b1, ALU_AND};
      FN_OR:   func_decode = {1'b1, ALU_OR};
      FN_SLT:  func_decode = {1'b1, ALU_SLT};
      default: func_decode = {1'b0, ALU_AND};
    endcase
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts stalled cycles of one memory access; flags the cycle on which the
// TIMEOUT-th consecutive stall would complete.
module mem_wait_timer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic init,
  input  logic clear,
  input  logic tick,
  output logic expired_c
);

  localparam int unsigned W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (init || clear) count <= '0;
    else if (tick)     count <= count + W'(1);
  end

  assign expired_c = tick && (count == W'(TIMEOUT - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for a multicycle MIPS datapath with memory handshake,
// per-access timeout, retired-instruction counter and sticky error state.
module multicycle_ctrl
  import mips_pkg::*;
#(
  parameter bit          MEM_HS  = 1'b1,
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             init,
  input  logic [5:0]       opcode,
  input  logic [5:0]       func,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             IorD,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             BrFlag,
  output logic             RegDst,
  output logic             WrSel,
  output logic             WdSel,
  output logic             RegWrite,
  output logic             ALUsrcA,
  output logic             MemtoReg,
  output logic             MemRead,
  output logic             MemWrite,
  output logic [1:0]       ALUsrcB,
  output logic [1:0]       PCsrc,
  output logic [2:0]       ALUoperation,
  output logic [CNT_W-1:0] retired,
  output logic             err
);

  state_t           state, state_next;
  logic [OP_W-1:0]  op_q, func_q;
  logic             func_ok;
  logic [ALU_W-1:0] func_alu;
  logic             in_mem, mem_done, timeout;
  ctrl_t            ctrl;
  logic             unused;

  // zero feeds the datapath's conditional PC write, not the sequencer
  assign unused = zero;

  assign in_mem   = (state == S_FETCH) || (state == S_MRD) || (state == S_MWR);
  assign mem_done = !MEM_HS || mem_ready;
  assign {func_ok, func_alu} = func_decode(func_q);

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait (
    .clk       (clk),
    .init      (init),
    .clear     (state_next != state),
    .tick      (MEM_HS && in_mem && !mem_ready),
    .expired_c (timeout)
  );

  // State register, IR field capture, retire counter, sticky error
  always_ff @(posedge clk) begin
    if (init) begin
      state   <= S_FETCH;
      op_q    <= '0;
      func_q  <= '0;
      retired <= '0;
      err     <= 1'b0;
    end else begin
      state <= state_next;
      if (state == S_DECODE) begin
        op_q   <= opcode;
        func_q <= func;
      end
      if (state_next == S_FETCH && state != S_FETCH) retired <= retired + CNT_W'(1);
      if (state_next == S_ERR) err <= 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH: begin
        if (mem_done)     state_next = S_DECODE;
        else if (timeout) state_next = S_ERR;
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:       state_next = (func == FN_JR) ? S_JR : S_EXR;
          OP_ADDI, OP_SLTI: state_next = S_EXI;
          OP_LW, OP_SW:   state_next = S_ADDR;
          OP_BEQ, OP_BNE: state_next = S_BR;
          OP_J:           state_next = S_JMP;
          OP_JAL:         state_next = S_JAL;
          default:        state_next = S_ERR;
        endcase
      end
      S_EXR:  state_next = func_ok ? S_WBR : S_ERR;
      S_EXI:  state_next = S_WBI;
      S_ADDR: state_next = (op_q == OP_LW) ? S_MRD : S_MWR;
      S_MRD: begin
        if (mem_done)     state_next = S_WBL;
        else if (timeout) state_next = S_ERR;
      end
      S_MWR: begin
        if (mem_done)     state_next = S_FETCH;
        else if (timeout) state_next = S_ERR;
      end
      S_WBR, S_WBI, S_WBL, S_BR, S_JMP, S_JAL, S_JR: state_next = S_FETCH;
      S_ERR:   state_next = S_ERR;
      default: state_next = S_ERR;
    endcase
  end

  // Control decode from state and the IR fields latched in DECODE
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.pc_write  = 1'b1;
        ctrl.alu_src_b = 2'b01;
        ctrl.alu_op    = ALU_ADD;
      end
      S_DECODE: begin
        ctrl.alu_src_b = 2'b11;
        ctrl.alu_op    = ALU_ADD;
      end
      S_EXR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = func_alu;
      end
      S_WBR: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      S_EXI: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        ctrl.alu_op    = (op_q == OP_SLTI) ? ALU_SLT : ALU_ADD;
      end
      S_WBI: ctrl.reg_write = 1'b1;
      S_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MRD: begin
        ctrl.iord     = 1'b1;
        ctrl.mem_read = 1'b1;
      end
      S_MWR: begin
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      S_WBL: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      S_BR: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_src        = 2'b01;
        ctrl.br_flag       = (op_q == OP_BNE);
      end
      S_JMP: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = 2'b10;
      end
      S_JAL: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_src    = 2'b10;
        ctrl.reg_write = 1'b1;
        ctrl.wr_sel    = 1'b1;
        ctrl.wd_sel    = 1'b1;
      end
      S_JR: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = 2'b11;
      end
      default: ctrl = '0;
    endcase
  end

  assign IorD         = ctrl.iord;
  assign IRWrite      = ctrl.ir_write;
  assign PCWrite      = ctrl.pc_write;
  assign PCWriteCond  = ctrl.pc_write_cond;
  assign BrFlag       = ctrl.br_flag;
  assign RegDst       = ctrl.reg_dst;
  assign WrSel        = ctrl.wr_sel;
  assign WdSel        = ctrl.wd_sel;
  assign RegWrite     = ctrl.reg_write;
  assign ALUsrcA      = ctrl.alu_src_a;
  assign MemtoReg     = ctrl.mem_to_reg;
  assign MemRead      = ctrl.mem_read;
  assign MemWrite     = ctrl.mem_write;
  assign ALUsrcB      = ctrl.alu_src_b;
  assign PCsrc        = ctrl.pc_src;
  assign ALUoperation = ctrl.alu_op;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction expected control sequences are
// planned from the instruction semantics, then replayed cycle by cycle.
module tb_multicycle_ctrl;

  localparam int unsigned TO = 15;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          init = 1'b1;
  logic [5:0]    opcode = '0;
  logic [5:0]    func = '0;
  logic          zero = 1'b0;
  logic          mem_ready = 1'b0;
  logic          IorD, IRWrite, PCWrite, PCWriteCond, BrFlag, RegDst, WrSel, WdSel;
  logic          RegWrite, ALUsrcA, MemtoReg, MemRead, MemWrite;
  logic [1:0]    ALUsrcB, PCsrc;
  logic [2:0]    ALUoperation;
  logic [CW-1:0] retired;
  logic          err;

  multicycle_ctrl #(.MEM_HS(1'b1), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .init(init), .opcode(opcode), .func(func), .zero(zero),
    .mem_ready(mem_ready), .IorD(IorD), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .PCWriteCond(PCWriteCond), .BrFlag(BrFlag), .RegDst(RegDst), .WrSel(WrSel),
    .WdSel(WdSel), .RegWrite(RegWrite), .ALUsrcA(ALUsrcA), .MemtoReg(MemtoReg),
    .MemRead(MemRead), .MemWrite(MemWrite), .ALUsrcB(ALUsrcB), .PCsrc(PCsrc),
    .ALUoperation(ALUoperation), .retired(retired), .err(err)
  );

  always #5 clk = ~clk;

  logic [20:0] obs;
  assign obs = {err, IorD, IRWrite, PCWrite, PCWriteCond, BrFlag, RegDst, WrSel, WdSel,
                RegWrite, ALUsrcA, MemtoReg, MemRead, MemWrite, ALUsrcB, PCsrc, ALUoperation};

  // One bit/field per control, in the same order as obs
  localparam logic [20:0] E_ERR = 21'(1) << 20, IORD = 21'(1) << 19, IRW = 21'(1) << 18;
  localparam logic [20:0] PCW = 21'(1) << 17, PCWC = 21'(1) << 16, BRF = 21'(1) << 15;
  localparam logic [20:0] RDST = 21'(1) << 14, WRS = 21'(1) << 13, WDS = 21'(1) << 12;
  localparam logic [20:0] RW = 21'(1) << 11, SA = 21'(1) << 10, M2R = 21'(1) << 9;
  localparam logic [20:0] MR = 21'(1) << 8, MW = 21'(1) << 7;
  localparam logic [20:0] SB4 = 21'(1) << 5, SBI = 21'(2) << 5, SBS = 21'(3) << 5;
  localparam logic [20:0] PC_O = 21'(1) << 3, PC_J = 21'(2) << 3, PC_R = 21'(3) << 3;
  localparam logic [20:0] A_ADD = 21'(2), A_SUB = 21'(6), A_AND = 21'(0), A_OR = 21'(1), A_SLT = 21'(7);

  localparam logic [20:0] W_FETCH  = MR | IRW | PCW | SB4 | A_ADD;
  localparam logic [20:0] W_DECODE = SBS | A_ADD;

  logic [20:0] exp_q[$];
  bit          rdy_q[$];
  bit          care_q[$];
  bit          dead;
  int          checks = 0;
  int          errors = 0;
  int          model_ret = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask

  task automatic push(input logic [20:0] w, input bit r, input bit c);
    exp_q.push_back(w);
    rdy_q.push_back(r);
    care_q.push_back(c);
  endtask

  // Non-memory cycle: mem_ready is irrelevant, so drive it randomly
  task automatic step(input logic [20:0] w);
    if (!dead) push(w, 1'($urandom_range(0, 1)), 1'b1);
  endtask

  // Memory access stalled for `wait_n` cycles; TO stalls in a row is fatal
  task automatic mem_stage(input logic [20:0] w, input int wait_n);
    if (dead) return;
    if (wait_n >= int'(TO)) begin
      repeat (TO) push(w, 1'b0, 1'b1);
      dead = 1'b1;
    end else begin
      repeat (wait_n) push(w, 1'b0, 1'b1);
      push(w, 1'b1, 1'b1);
    end
  endtask

  function automatic int alu_of(input logic [5:0] fn);
    case (fn)
      6'h20:   return 2;
      6'h22:   return 6;
      6'h24:   return 0;
      6'h25:   return 1;
      6'h2A:   return 7;
      default: return -1;
    endcase
  endfunction

  task automatic plan(input logic [5:0] op, input logic [5:0] fn, input int wf, input int wd);
    exp_q.delete(); rdy_q.delete(); care_q.delete();
    dead = 1'b0;
    mem_stage(W_FETCH, wf);
    step(W_DECODE);
    if (!dead) begin
      case (op)
        6'h00: begin
          if (fn == 6'h08) step(PCW | PC_R);
          else if (alu_of(fn) >= 0) begin
            step(SA | 21'(alu_of(fn)));
            step(RDST | RW);
          end else begin
            push('0, 1'b0, 1'b0);   // EXR with an illegal func: ALU op unspecified
            dead = 1'b1;
          end
        end
        6'h08:   begin step(SA | SBI | A_ADD); step(RW); end
        6'h0A:   begin step(SA | SBI | A_SLT); step(RW); end
        6'h23:   begin step(SA | SBI | A_ADD); mem_stage(IORD | MR, wd); step(M2R | RW); end
        6'h2B:   begin step(SA | SBI | A_ADD); mem_stage(IORD | MW, wd); end
        6'h04:   step(SA | A_SUB | PCWC | PC_O);
        6'h05:   step(SA | A_SUB | PCWC | PC_O | BRF);
        6'h02:   step(PCW | PC_J);
        6'h03:   step(PCW | PC_J | RW | WRS | WDS);
        default: dead = 1'b1;
      endcase
    end
    if (dead) repeat (3) push(E_ERR, 1'($urandom_range(0, 1)), 1'b1);
  endtask

  // Replay the plan from a FETCH-state negedge; limit < 0 means the whole plan
  task automatic run(input string tag, input logic [5:0] op, input logic [5:0] fn, input int limit);
    int n;
    chk({tag, "_retired_in"}, 32'(retired), 32'(model_ret));
    opcode = op;
    func = fn;
    n = (limit < 0) ? exp_q.size() : limit;
    for (int i = 0; i < n; i++) begin
      if (care_q[i]) chk($sformatf("%s_cyc%0d", tag, i), 32'(obs), 32'(exp_q[i]));
      mem_ready = rdy_q[i];
      zero = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
    end
    if (limit < 0 && !dead) model_ret = (model_ret + 1) % (1 << CW);
  endtask

  task automatic do_init(input string tag);
    init = 1'b1;
    mem_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    init = 1'b0;
    model_ret = 0;
    chk({tag, "_ctrl"}, 32'(obs), 32'(W_FETCH));
    chk({tag, "_retired"}, 32'(retired), 32'(0));
  endtask

  task automatic instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                       input int wf, input int wd);
    plan(op, fn, wf, wd);
    run(tag, op, fn, -1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] ops[14];
    logic [5:0] fns[14];
    int k;
    ops = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h0A, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h08, 6'h11, 6'h12, 6'h13, 6'h14, 6'h15, 6'h16, 6'h17, 6'h18};

    repeat (2) @(posedge clk);
    @(negedge clk);
    init = 1'b0;
    chk("reset_ctrl", 32'(obs), 32'(W_FETCH));
    chk("reset_retired", 32'(retired), 32'(0));

    instr("add", 6'h00, 6'h20, 0, 0);
    instr("lw_wait3", 6'h23, 6'h00, 0, 3);
    instr("bne", 6'h05, 6'h00, 1, 0);
    instr("jal", 6'h03, 6'h00, 0, 0);
    instr("beq", 6'h04, 6'h00, 0, 0);
    instr("jr", 6'h00, 6'h08, 2, 0);
    instr("slti", 6'h0A, 6'h00, 0, 0);
    instr("sw", 6'h2B, 6'h00, 0, 2);
    instr("fetch_wait14", 6'h00, 6'h22, 14, 0);
    instr("lw_wait14", 6'h23, 6'h00, 0, 14);

    // Random mix; retired wraps through 2^CW several times
    for (int i = 0; i < 40; i++) begin
      k = int'($urandom_range(0, 13));
      instr($sformatf("rnd%0d", i), ops[k], fns[k], int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));
    end

    instr("fetch_timeout", 6'h00, 6'h20, 15, 0);
    chk("timeout_err_held", 32'(err), 32'(1));
    do_init("init_after_timeout");

    instr("lw_timeout", 6'h23, 6'h00, 0, 15);
    do_init("init_after_mrd_timeout");

    instr("bad_opcode", 6'h3F, 6'h00, 0, 0);
    chk("bad_opcode_err", 32'(obs), 32'(E_ERR));
    do_init("init_from_err");

    instr("pre_or", 6'h00, 6'h25, 0, 0);
    plan(6'h2B, 6'h00, 0, 6);
    run("sw_cut", 6'h2B, 6'h00, 5);
    chk("mid_mwr_ctrl", 32'(obs), 32'(IORD | MW));
    do_init("init_mid_mwr");

    instr("bad_func", 6'h00, 6'h3F, 0, 0);
    do_init("init_after_bad_func");

    instr("and_last", 6'h00, 6'h24, 1, 0);
    chk("final_retired", 32'(retired), 32'(model_ret));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL take parameter MEM_HS, default 1: 1 = memory states wait for mem_ready; 0 = memory completes in one cycle and mem_ready is ignored.
REQ-002 SHALL take parameter TIMEOUT, default 15: maximum wait cycles for any single memory access.
REQ-003 SHALL take parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-004 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port init, input, 1: synchronous active-high reset.
REQ-006 SHALL have port opcode, input, 6: IR[31:26].
REQ-007 SHALL have port func, input, 6: IR[5:0].
REQ-008 SHALL have port zero, input, 1: ALU zero flag.
REQ-009 SHALL have port mem_ready, input, 1: memory access complete this cycle.
REQ-010 SHALL have ports IorD, IRWrite, PCWrite, PCWriteCond, BrFlag, RegDst, WrSel, WdSel, RegWrite, ALUsrcA, MemtoReg, MemRead, MemWrite, output, 1 each: datapath controls.
- WrSel = write register $31.
- WdSel = write-data is PC.
- BrFlag = branch on !zero.
REQ-011 SHALL have ports ALUsrcB and PCsrc, output, 2 each.
- ALUsrcB: 00 reg, 01 const 4, 10 sign-extended imm, 11 imm<<2.
- PCsrc: 00 ALU, 01 ALUOut, 10 jump target, 11 register.
REQ-012 SHALL have port ALUoperation, output, 3: ALU opcode.
- 010 add, 110 sub, 000 and, 001 or, 111 slt.
REQ-013 SHALL have port retired, output, CNT_W: count of completed instructions.
REQ-014 SHALL have port err, output, 1: sticky fault flag.

Function
REQ-015 SHALL be a Moore FSM; all outputs are decoded from state only, and any control not listed for a state is 0.
REQ-016 SHALL have states FETCH, DECODE, EXR, WBR, EXI, WBI, ADDR, MRD, WBL, MWR, BR, JMP, JAL, JR, ERR.
REQ-017 FETCH SHALL assert MemRead, IRWrite, PCWrite, ALUsrcB=01, ALUoperation=010; advance to DECODE when mem_ready (or unconditionally if MEM_HS=0), else remain.
REQ-018 DECODE SHALL assert ALUsrcB=11, ALUoperation=010, and dispatch on opcode:
- 000000 with func=001000 -> JR; other 000000 -> EXR.
- 001000 (addi) and 001010 (slti) -> EXI.
- 100011 and 101011 -> ADDR.
- 000100 and 000101 -> BR.
- 000010 -> JMP; 000011 -> JAL.
- anything else -> ERR.
REQ-019 EXR SHALL assert ALUsrcA and map func to ALUoperation: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt; any other func -> ERR.
REQ-020 WBR SHALL assert RegDst and RegWrite, then go to FETCH.
REQ-021 EXI SHALL assert ALUsrcA, ALUsrcB=10, and ALUoperation=010 for addi or 111 for slti; WBI SHALL assert RegWrite, then go to FETCH.
REQ-022 ADDR SHALL assert ALUsrcA, ALUsrcB=10, ALUoperation=010, and go to MRD for lw or MWR for sw.
REQ-023 MRD and MWR SHALL assert IorD plus MemRead or MemWrite respectively, holding until mem_ready; MRD then goes to WBL, MWR to FETCH.
REQ-024 WBL SHALL assert MemtoReg and RegWrite, then go to FETCH.
REQ-025 BR SHALL assert ALUsrcA, ALUoperation=110, PCWriteCond, PCsrc=01, and BrFlag for opcode 000101 only, then go to FETCH.
REQ-026 JMP SHALL assert PCWrite and PCsrc=10; JAL SHALL additionally assert RegWrite, WrSel, WdSel; JR SHALL assert PCWrite and PCsrc=11; each then goes to FETCH.
REQ-027 SHALL keep a wait counter cleared on entry to each memory state and incremented per cycle without mem_ready; reaching TIMEOUT SHALL enter ERR.
REQ-028 ERR SHALL drive all controls 0, set err=1, and persist until init.
REQ-029 retired SHALL increment by 1 on every transition into FETCH from a non-FETCH state and wrap modulo 2^CNT_W.
REQ-030 When mem_ready and the timeout occur in the same cycle, mem_ready SHALL win.

Reset
REQ-031 init=1 at a clock edge SHALL force FETCH, clear retired, the wait counter and err, regardless of current state, including mid-access and ERR.

Structure
REQ-032 Opcode, func and ALUoperation constants and the state encoding SHALL reside in shared package mips_pkg.
REQ-033 The wait/timeout counter SHALL be one sub-module, mem_wait_timer.

Verification
REQ-034 add R-type, mem_ready=1 every cycle -> FETCH, DECODE, EXR, WBR, FETCH; RegDst=RegWrite=1 in WBR; retired 0->1.
REQ-035 lw with mem_ready low 3 cycles in MRD -> MemRead=IorD=1 for 4 cycles, then WBL with MemtoReg=1.
REQ-036 bne with zero=0 -> BR shows PCWriteCond=1, BrFlag=1, PCsrc=01.
REQ-037 mem_ready held 0 in FETCH with TIMEOUT=15 -> ERR after 15 cycles, err=1 until init.
REQ-038 opcode 111111 -> ERR; then init in mid-MWR -> FETCH, retired=0, err=0 next cycle.
REQ-039 jal -> JAL state asserts PCWrite, RegWrite, WrSel, WdSel, PCsrc=10.
